// File: rtl/prog_mem_arbiter_if.sv
// Signal bundle between the fetch port, the loader port, the arbiter and the program memory.
// The arbiter uses the slave view; the environment (core, loader, memory model) uses the master view.
interface prog_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_fault;

    logic        ld_req;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt;
    logic        ld_done;
    logic [31:0] ld_rdata;
    logic        ld_fault;

    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_fault,
        output ld_gnt, ld_done, ld_rdata, ld_fault,
        output mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_fault,
        input  ld_gnt, ld_done, ld_rdata, ld_fault,
        input  mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_mem_arbiter.sv
// Program-memory arbiter: round-robin between fetch (IF) and loader (LD), window check, timed access.
// Saturating access/fault counters are built only when PROG_ARB_STATS_EN is defined.
module prog_mem_arbiter #(
    parameter logic [31:0] BASE_ADDR   = 32'h240,
    parameter logic [31:0] LAST_ADDR   = 32'h123F,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    prog_mem_arbiter_if.slave  bus,
    output logic [15:0]        stat_access,
    output logic [15:0]        stat_fault
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, FAULT} state_t;

    state_t      state;
    logic        last_ld;
    logic        cap_ld;
    logic [3:0]  cnt;

    logic        any_req;
    logic        pick_ld;
    logic        sel_we;
    logic        in_window;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    // On a tie the loader wins only if fetch was served last.
    assign any_req   = bus.if_req | bus.ld_req;
    assign pick_ld   = bus.ld_req & (~bus.if_req | ~last_ld);
    assign sel_addr  = pick_ld ? bus.ld_addr : bus.if_addr;
    assign sel_we    = pick_ld & bus.ld_we;
    assign sel_wdata = pick_ld ? bus.ld_wdata : 32'h0;
    assign in_window = (sel_addr >= BASE_ADDR) && (sel_addr <= LAST_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_ld       <= 1'b1;
            cap_ld        <= 1'b0;
            cnt           <= 4'd0;
            bus.if_gnt    <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.if_rdata  <= 32'h0;
            bus.if_fault  <= 1'b0;
            bus.ld_gnt    <= 1'b0;
            bus.ld_done   <= 1'b0;
            bus.ld_rdata  <= 32'h0;
            bus.ld_fault  <= 1'b0;
            bus.mem_cs    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'h0;
            bus.mem_wdata <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments here, so every read below sees the pre-edge value.
            bus.if_gnt    <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.if_rdata  <= 32'h0;
            bus.if_fault  <= 1'b0;
            bus.ld_gnt    <= 1'b0;
            bus.ld_done   <= 1'b0;
            bus.ld_rdata  <= 32'h0;
            bus.ld_fault  <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        last_ld    <= pick_ld;
                        cap_ld     <= pick_ld;
                        bus.if_gnt <= ~pick_ld;
                        bus.ld_gnt <= pick_ld;
                        if (in_window) begin
                            state         <= ACCESS;
                            bus.mem_cs    <= 1'b1;
                            bus.mem_we    <= sel_we;
                            bus.mem_addr  <= sel_addr - BASE_ADDR;
                            bus.mem_wdata <= sel_wdata;
                            cnt           <= 4'(MEM_LATENCY - 1);
                        end else begin
                            state         <= FAULT;
                            bus.if_rvalid <= ~pick_ld;
                            bus.if_fault  <= ~pick_ld;
                            bus.ld_done   <= pick_ld;
                            bus.ld_fault  <= pick_ld;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state         <= RESP;
                        bus.mem_cs    <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= 32'h0;
                        bus.mem_wdata <= 32'h0;
                        if (cap_ld) begin
                            bus.ld_done  <= 1'b1;
                            bus.ld_rdata <= bus.mem_we ? 32'h0 : bus.mem_rdata;
                        end else begin
                            bus.if_rvalid <= 1'b1;
                            bus.if_rdata  <= bus.mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PROG_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_access <= 16'h0;
            stat_fault  <= 16'h0;
        end else begin
            if (state == RESP && stat_access != 16'hFFFF)
                stat_access <= stat_access + 16'd1;
            if (state == FAULT && stat_fault != 16'hFFFF)
                stat_fault <= stat_fault + 16'd1;
        end
    end
`else
    assign stat_access = 16'h0;
    assign stat_fault  = 16'h0;
`endif
endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed bench for prog_mem_arbiter: a cycle-schedule model checked every cycle,
// plus literal expectations for the window edges, write path, contention and mid-access reset.
`timescale 1ns/1ps
module tb_prog_mem_arbiter;
    localparam logic [31:0] BASE = 32'h240;
    localparam logic [31:0] LAST = 32'h123F;
    localparam int          LAT  = 2;
    localparam int          N    = 64;

    typedef struct packed {
        logic        if_gnt;
        logic        if_rvalid;
        logic        if_fault;
        logic [31:0] if_rdata;
        logic        ld_gnt;
        logic        ld_done;
        logic        ld_fault;
        logic [31:0] ld_rdata;
        logic        mem_cs;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } obs_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] stat_access;
    logic [15:0] stat_fault;

    prog_mem_arbiter_if b ();

    prog_mem_arbiter #(
        .BASE_ADDR  (BASE),
        .LAST_ADDR  (LAST),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (b),
        .stat_access(stat_access),
        .stat_fault (stat_fault)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;

    // Expected outputs per cycle; cycle k is the interval that starts at rising edge k.
    obs_t sched [N];
    int   cyc       = 0;
    int   free_edge = 0;
    int   cap_edge  = -1;
    bit   m_last_ld = 1'b1;
    bit   cap_ld    = 1'b0;
    bit   cap_we    = 1'b0;
    int   n_acc     = 0;
    int   n_flt     = 0;
    bit   cmp_en    = 1'b0;

    logic [31:0] g_addr, g_wdata, r_data;
    logic        g_cs, g_we, g_fault, r_fault;
    int          lat;
    bit          got_gnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_obs(input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL cycle %0d outputs: got %h, expected %h", cyc, act, exp);
    endtask

    // Model: a request seen while the port pair is free is scheduled as a whole timeline.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < N; i++) sched[i] = '0;
            free_edge = 0;
            cap_edge  = -1;
            m_last_ld = 1'b1;
            n_acc     = 0;
            n_flt     = 0;
        end else begin
            cyc++;
            if (cyc == cap_edge) begin
                if (cap_ld) sched[cyc % N].ld_rdata = cap_we ? 32'h0 : b.mem_rdata;
                else        sched[cyc % N].if_rdata = b.mem_rdata;
            end
            if (cyc >= free_edge && (b.if_req || b.ld_req)) begin
                bit          ld;
                bit          we;
                logic [31:0] a;
                logic [31:0] wd;
                ld = b.ld_req && (!b.if_req || !m_last_ld);
                m_last_ld = ld;
                a  = ld ? b.ld_addr : b.if_addr;
                we = ld && b.ld_we;
                wd = ld ? b.ld_wdata : 32'h0;
                if (ld) sched[cyc % N].ld_gnt = 1'b1;
                else    sched[cyc % N].if_gnt = 1'b1;
                if (a >= BASE && a <= LAST) begin
                    for (int k = 0; k < LAT; k++) begin
                        sched[(cyc + k) % N].mem_cs    = 1'b1;
                        sched[(cyc + k) % N].mem_we    = we;
                        sched[(cyc + k) % N].mem_addr  = a - BASE;
                        sched[(cyc + k) % N].mem_wdata = wd;
                    end
                    if (ld) sched[(cyc + LAT) % N].ld_done   = 1'b1;
                    else    sched[(cyc + LAT) % N].if_rvalid = 1'b1;
                    cap_edge  = cyc + LAT;
                    cap_ld    = ld;
                    cap_we    = we;
                    free_edge = cyc + LAT + 2;
                    n_acc++;
                end else begin
                    if (ld) begin
                        sched[cyc % N].ld_done  = 1'b1;
                        sched[cyc % N].ld_fault = 1'b1;
                    end else begin
                        sched[cyc % N].if_rvalid = 1'b1;
                        sched[cyc % N].if_fault  = 1'b1;
                    end
                    free_edge = cyc + 2;
                    n_flt++;
                end
            end
        end
    end

    // Every-cycle compare; write-side memory fields only matter while chip select is expected.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            obs_t e;
            obs_t a;
            e = sched[cyc % N];
            a = {b.if_gnt, b.if_rvalid, b.if_fault, b.if_rdata,
                 b.ld_gnt, b.ld_done, b.ld_fault, b.ld_rdata,
                 b.mem_cs, b.mem_we, b.mem_addr, b.mem_wdata};
            if (!e.mem_cs) begin
                a.mem_we    = 1'b0;
                a.mem_addr  = 32'h0;
                a.mem_wdata = 32'h0;
            end
            check_obs(a, e);
            sched[cyc % N] = '0;
        end
    end

    task automatic wait_gnt(input bit ld);
        int n = 0;
        got_gnt = 1'b0;
        while (!got_gnt && n < 20) begin
            @(negedge clk);
            n++;
            if (ld ? b.ld_gnt : b.if_gnt) got_gnt = 1'b1;
        end
        if (!got_gnt) check("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic access(input bit ld, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd);
        bit done;
        @(negedge clk);
        b.mem_rdata = rd;
        if (ld) begin
            b.ld_req = 1'b1; b.ld_we = we; b.ld_addr = addr; b.ld_wdata = wd;
        end else begin
            b.if_req = 1'b1; b.if_addr = addr;
        end
        wait_gnt(ld);
        if (!got_gnt) begin
            b.if_req = 1'b0; b.ld_req = 1'b0;
            return;
        end
        g_cs    = b.mem_cs;
        g_we    = b.mem_we;
        g_addr  = b.mem_addr;
        g_wdata = b.mem_wdata;
        g_fault = ld ? (b.ld_done & b.ld_fault) : (b.if_rvalid & b.if_fault);
        // Captured values must survive the requester moving on right after the grant.
        b.if_req   = 1'b0;
        b.ld_req   = 1'b0;
        b.if_addr  = 32'h248;
        b.ld_addr  = 32'h248;
        b.ld_wdata = ~wd;
        b.ld_we    = ~we;
        lat  = 0;
        done = ld ? b.ld_done : b.if_rvalid;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            done = ld ? b.ld_done : b.if_rvalid;
        end
        if (!done) check("resp_timeout", 32'd0, 32'd1);
        r_data  = ld ? b.ld_rdata : b.if_rdata;
        r_fault = ld ? b.ld_fault : b.if_fault;
    endtask

    initial begin
        logic [31:0] bad [4];
        int          order [4];
        int          n_g;
        int          guard;
        int          cnt_seen;

        bad = '{32'h230, 32'h2F0F, 32'h23F, 32'h1240};
        b.if_req = 1'b0; b.if_addr = 32'h0;
        b.ld_req = 1'b0; b.ld_we = 1'b0; b.ld_addr = 32'h0; b.ld_wdata = 32'h0;
        b.mem_rdata = 32'h0;
        for (int i = 0; i < N; i++) sched[i] = '0;

        repeat (2) @(negedge clk);
        check("rst_mem_cs", b.mem_cs, 32'd0);
        check("rst_if_gnt", b.if_gnt, 32'd0);
        check("rst_ld_rdata", b.ld_rdata, 32'd0);
        check("rst_stat_access", stat_access, 32'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        access(1'b0, 1'b0, 32'h240, 32'h0, 32'h00500093);
        check("base_cs", g_cs, 32'd1);
        check("base_mem_addr", g_addr, 32'h0);
        check("base_latency", lat, LAT);
        check("base_rdata", r_data, 32'h00500093);
        check("base_fault", r_fault, 32'd0);

        access(1'b0, 1'b0, 32'h123F, 32'h0, 32'h0000_0013);
        check("last_mem_addr", g_addr, 32'hFFF);
        check("last_fault", r_fault, 32'd0);

        for (int i = 0; i < 4; i++) begin
            access(1'b0, 1'b0, bad[i], 32'h0, 32'hFFFF_FFFF);
            check("oob_cs", g_cs, 32'd0);
            check("oob_fault_with_gnt", g_fault, 32'd1);
            check("oob_latency", lat, 32'd0);
            check("oob_rdata", r_data, 32'h0);
        end

        access(1'b1, 1'b1, 32'h300, 32'hDEADBEEF, 32'h1234_5678);
        check("ldw_cs", g_cs, 32'd1);
        check("ldw_we", g_we, 32'd1);
        check("ldw_mem_addr", g_addr, 32'hC0);
        check("ldw_mem_wdata", g_wdata, 32'hDEADBEEF);
        check("ldw_latency", lat, LAT);
        check("ldw_rdata", r_data, 32'h0);

        access(1'b1, 1'b0, 32'h1000, 32'h0, 32'hCAFEF00D);
        check("ldr_we", g_we, 32'd0);
        check("ldr_mem_addr", g_addr, 32'hDC0);
        check("ldr_rdata", r_data, 32'hCAFEF00D);

        access(1'b1, 1'b1, 32'h0, 32'h5A5A5A5A, 32'h0);
        check("ld_oob_fault", g_fault, 32'd1);

        // Contention: both ports held high, fetch expected first after a loader access.
        @(negedge clk);
        b.mem_rdata = 32'h1111_2222;
        b.if_req = 1'b1; b.if_addr = 32'h600;
        b.ld_req = 1'b1; b.ld_we = 1'b0; b.ld_addr = 32'h700;
        order = '{7, 7, 7, 7};
        n_g   = 0;
        guard = 0;
        while (n_g < 4 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (b.if_gnt) begin order[n_g] = 0; n_g++; end
            if (b.ld_gnt && n_g < 4) begin order[n_g] = 1; n_g++; end
        end
        b.if_req = 1'b0;
        b.ld_req = 1'b0;
        check("contention_grants", n_g, 32'd4);
        check("order0_if", order[0], 32'd0);
        check("order1_ld", order[1], 32'd1);
        check("order2_if", order[2], 32'd0);
        check("order3_ld", order[3], 32'd1);
        repeat (LAT + 3) @(negedge clk);

        // A loader request raised and dropped while fetch is busy must never be served.
        b.mem_rdata = 32'h3333_4444;
        b.if_req = 1'b1; b.if_addr = 32'h800;
        wait_gnt(1'b0);
        b.if_req = 1'b0;
        b.ld_req = 1'b1; b.ld_addr = 32'h900;
        @(negedge clk);
        b.ld_req = 1'b0;
        cnt_seen = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (b.ld_gnt || b.ld_done) cnt_seen++;
        end
        check("dropped_ld_never_served", cnt_seen, 32'd0);

        // Reset on the second cycle of an access.
        b.mem_rdata = 32'h5555_6666;
        b.if_req = 1'b1; b.if_addr = 32'h400;
        wait_gnt(1'b0);
        b.if_req = 1'b0;
        @(posedge clk);
        #1;
        check("mid_access_cs", b.mem_cs, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_cs", b.mem_cs, 32'd0);
        check("async_rst_addr", b.mem_addr, 32'h0);
        check("async_rst_gnt", b.if_gnt, 32'd0);
        cnt_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (b.if_rvalid) cnt_seen++;
        end
        check("rst_no_rvalid", cnt_seen, 32'd0);
        rst_n = 1'b1;

        access(1'b0, 1'b0, 32'h500, 32'h0, 32'h0A0B0C0D);
        check("post_rst_rdata", r_data, 32'h0A0B0C0D);
        check("post_rst_latency", lat, LAT);
        access(1'b1, 1'b1, 32'h1100, 32'h7777_8888, 32'h0);
        access(1'b1, 1'b0, 32'h1200, 32'h0, 32'h9999_AAAA);
        check("stats_ldr_rdata", r_data, 32'h9999_AAAA);
        access(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        access(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
`ifdef PROG_ARB_STATS_EN
        check("stat_access_lit", stat_access, 32'd3);
        check("stat_fault_lit", stat_fault, 32'd2);
        check("stat_access_model", stat_access, n_acc);
        check("stat_fault_model", stat_fault, n_flt);
`else
        check("stat_access_off", stat_access, 32'd0);
        check("stat_fault_off", stat_fault, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
